loop_capture_buf: RTL
=====================

Name: loop_capture_buf

Overview:
Parametrised counter-and-capture buffer. A free-running wrap-limited up-counter is sampled into a DEPTH-entry register buffer under a start/stop control FSM, in one-shot or circular mode. The buffer is read back through a registered random-access port. Used as a debug/trace capture element in loop and counter test structures.

Parameters:
WIDTH, 4, bit width of counter, limit and buffer entries (>=2)
DEPTH, 8, number of buffer entries (power of 2, >=2); AW = clog2(DEPTH)

Ports:
clk  input  1  clock, all state on rising edge
rstn  input  1  asynchronous active-low reset
enable  input  1  counter advance and capture qualifier
limit  input  WIDTH  counter wrap value (counts 0..limit)
mode  input  1  0 = one-shot, 1 = circular; sampled on accepted start
start  input  1  begin capture (single-cycle pulse)
stop  input  1  end capture early / end circular capture
clear  input  1  synchronous clear of buffer and capture state
rd_addr  input  AW  read address
rd_data  output  WIDTH  registered buffer read data
cnt  output  WIDTH  current counter value
busy  output  1  high in CAPTURE
done  output  1  high in DONE
wr_ptr  output  AW  next write address
wrapped  output  1  circular capture has wrapped at least once

Behaviour:
- Reset (rstn low, async): cnt=0, all buffer entries=0, rd_data=0, state IDLE, wr_ptr=0, busy=0, done=0, wrapped=0, latched mode=0. Reset mid-capture aborts; no partial write on the reset edge.
- Counter: on each edge with enable=1, if cnt>=limit then cnt<=0 else cnt<=cnt+1. Holds when enable=0. Unaffected by clear, start or stop. limit=0 holds cnt at 0.
- FSM states: IDLE, CAPTURE, DONE. busy = (CAPTURE); done = (DONE).
- Priority per edge: clear > start/stop > capture write.
- clear=1: all entries<=0, state<=IDLE, wr_ptr<=0, wrapped<=0. Counter keeps running. Any simultaneous start is ignored.
- start=1 in IDLE or DONE: state<=CAPTURE, wr_ptr<=0, wrapped<=0, latched mode<=mode. The buffer is not cleared. No write occurs on the start edge. start in CAPTURE is ignored.
- CAPTURE, enable=1: buf[wr_ptr]<=cnt (the pre-increment value), wr_ptr<=wr_ptr+1 (mod DEPTH). enable=0: no write, wr_ptr holds.
- One-shot: the write to DEPTH-1 also moves state to DONE, with wr_ptr wrapping to 0.
- Circular: when wr_ptr wraps DEPTH-1 to 0, wrapped<=1. Capture continues until stop.
- stop=1 in CAPTURE: any write qualified on the same edge still occurs, then state<=DONE. stop in IDLE or DONE is ignored. stop and start on the same edge in DONE: start wins.
- Read: rd_data<=buf[rd_addr] every edge, giving 1-cycle latency. Reading the address written on the same edge returns the old contents. rd_data is not cleared by clear.

Test Plan:
1. Reset: WIDTH=4, DEPTH=8, limit=10, enable=1, start one-shot, pulse rstn low after 3 writes -> cnt=0, busy=0, done=0, wr_ptr=0; all 8 reads return 0.
2. One-shot: limit=10, enable=1, start pulsed on the edge where cnt goes 3->4 -> buf[0..7]=4,5,6,7,8,9,10,0; done=1 on the 8th write edge; wr_ptr=0; wrapped=0.
3. Circular: limit=15, cnt=0 at the start edge, 11 enabled writes with stop on the 11th -> buf=9,10,11,4,5,6,7,8; wr_ptr=3; wrapped=1; done=1.
4. Enable gaps: one-shot with enable toggling 1,0,1,0... -> exactly 8 writes of consecutive cnt values; done after 16 cycles; cnt advances only on enabled edges.
5. Priority: clear and start on the same edge during DONE -> state IDLE, busy=0, done=0, all entries read 0. A second start pulsed in CAPTURE -> wr_ptr not reset.
6. Limit change: cnt=9, limit changed to 5, enable=1 -> cnt=0 next edge, then counts 1..5, 0. Read of rd_addr=2 returns data one cycle after the address is applied.

Source files
------------

// File: rtl/loop_capture_buf_if.sv
// loop_capture_buf_if: control, status and read-port bundle for loop_capture_buf.
//   master modport: drives enable/limit/mode/start/stop/clear/rd_addr, observes status.
//   slave modport : the capture buffer; drives rd_data/cnt/busy/done/wr_ptr/wrapped.
interface loop_capture_buf_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic             enable;
    logic [WIDTH-1:0] limit;
    logic             mode;
    logic             start;
    logic             stop;
    logic             clear;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic [WIDTH-1:0] cnt;
    logic             busy;
    logic             done;
    logic [AW-1:0]    wr_ptr;
    logic             wrapped;

    modport master (
        output enable, limit, mode, start, stop, clear, rd_addr,
        input  rd_data, cnt, busy, done, wr_ptr, wrapped
    );

    modport slave (
        input  enable, limit, mode, start, stop, clear, rd_addr,
        output rd_data, cnt, busy, done, wr_ptr, wrapped
    );
endinterface

// File: rtl/loop_capture_buf.sv
// loop_capture_buf: wrap-limited up-counter sampled into a DEPTH-entry buffer.
//   clk  : clock, all state on rising edge
//   rstn : asynchronous active-low reset
//   bus  : loop_capture_buf_if.slave
//          inputs  enable, limit, mode (0 one-shot / 1 circular), start, stop, clear, rd_addr
//          outputs rd_data (registered read), cnt, busy, done, wr_ptr, wrapped
// Edge priority: clear > start/stop > capture write.
module loop_capture_buf #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    loop_capture_buf_if.slave     bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StCapture, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic             wrapped_q, wrapped_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;
    logic             we;
    logic             mem_clr;

    // Free-running counter, independent of the capture control.
    always_comb begin
        cnt_d = cnt_q;
        if (bus.enable) begin
            cnt_d = (cnt_q >= bus.limit) ? '0 : cnt_q + WIDTH'(1);
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        wrapped_d = wrapped_q;
        mode_d    = mode_q;
        we        = 1'b0;
        mem_clr   = 1'b0;
        if (bus.clear) begin
            mem_clr   = 1'b1;
            state_d   = StIdle;
            wr_ptr_d  = '0;
            wrapped_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    // Start wins over a simultaneous stop here; the start edge never writes.
                    if (bus.start) begin
                        state_d   = StCapture;
                        wr_ptr_d  = '0;
                        wrapped_d = 1'b0;
                        mode_d    = bus.mode;
                    end
                end
                StCapture: begin
                    if (bus.enable) begin
                        we       = 1'b1;
                        wr_ptr_d = wr_ptr_q + AW'(1);
                        if (wr_ptr_q == AW'(DEPTH - 1)) begin
                            if (mode_q) begin
                                wrapped_d = 1'b1;
                            end else begin
                                state_d = StDone;
                            end
                        end
                    end
                    // The write qualified on this edge still lands before stopping.
                    if (bus.stop) begin
                        state_d = StDone;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            wr_ptr_q  <= '0;
            wrapped_q <= 1'b0;
            mode_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            wrapped_q <= wrapped_d;
            mode_q    <= mode_d;
        end
    end

    // Buffer and read register. A read of the address being written returns the old entry.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_data_q <= '0;
        end else begin
            if (mem_clr) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem_q[i] <= '0;
                end
            end else if (we) begin
                mem_q[wr_ptr_q] <= cnt_q;
            end
            rd_data_q <= mem_q[bus.rd_addr];
        end
    end

    assign bus.rd_data = rd_data_q;
    assign bus.cnt     = cnt_q;
    assign bus.busy    = (state_q == StCapture);
    assign bus.done    = (state_q == StDone);
    assign bus.wr_ptr  = wr_ptr_q;
    assign bus.wrapped = wrapped_q;
endmodule
